// File: rtl/uart_rx_wb.sv
// uart_rx_wb: 8N1 UART receiver feeding a small byte FIFO, drained by a
// Wishbone classic write controller. Framing errors and overruns are
// reported as single-cycle pulses.
module uart_rx_wb #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       uart_rx,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [7:0] wb_dat_o,
    input  logic       wb_ack_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAIT_HIGH
    } rx_state_t;

    typedef enum logic {
        WB_IDLE, WB_BUSY
    } wb_state_t;

    rx_state_t        rx_state;
    wb_state_t        wb_state;

    logic             rx_p0;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [LVL_W-1:0] level;

    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;

    // A byte is offered to the FIFO in the cycle the stop bit is sampled high.
    assign push  = (rx_state == STOP) && (cnt == CNT_LAST) && rx_s;
    assign pop   = (wb_state == WB_BUSY) && wb_ack_i;
    assign full  = (level == LVL_FULL);
    // When full, a simultaneous pop frees the slot the push needs.
    assign wr_en = push && (!full || pop);

    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = wb_cyc_o;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= uart_rx;
            rx_s  <= rx_p0;
        end
    end

    // Receive FSM: start detect, mid-bit sampling, stop check, break wait.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_state    <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            case (rx_state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        rx_state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A line that is high again by mid start bit was a glitch.
                        rx_state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Leave mid stop bit so a back-to-back start edge is caught.
                            rx_state <= IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            rx_state    <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    cnt <= '0;
                    if (rx_s) begin
                        rx_state <= IDLE;
                    end
                end
                default: begin
                    rx_state <= IDLE;
                    cnt      <= '0;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset since the level gates every read.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr] <= shreg;
        end
    end

    // FIFO pointers, fill level and overrun pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= push && full && !pop;
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Wishbone write controller: one classic cycle per buffered byte.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wb_state <= WB_IDLE;
            wb_cyc_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            case (wb_state)
                WB_IDLE: begin
                    if (level != '0) begin
                        wb_cyc_o <= 1'b1;
                        wb_dat_o <= mem[rptr];
                        wb_state <= WB_BUSY;
                    end
                end
                WB_BUSY: begin
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_state <= WB_IDLE;
                    end
                end
                default: begin
                    wb_cyc_o <= 1'b0;
                    wb_state <= WB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_wb.sv
// tb_uart_rx_wb: directed self-checking bench for uart_rx_wb with
// CLKS_PER_BIT=16 and FIFO_DEPTH=4.
module tb_uart_rx_wb;

    localparam int CPB = 16;

    logic       clk_i;
    logic       rst_ni;
    logic       uart_rx;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_we_o;
    logic [7:0] wb_dat_o;
    logic       wb_ack_i;
    logic       frame_err_o;
    logic       overrun_o;

    int n_cmp = 0;
    int n_bad = 0;

    // ack_mode: 0 = ack one cycle after stb rises, 1 = tied high, 2 = held low
    int ack_mode = 0;
    int cyc_age  = 0;

    logic [7:0] wr_q [$];
    int we_bad   = 0;
    int sig_bad  = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int run      = 0;
    int last_run = 0;
    int gap      = 0;
    int min_gap  = 999;
    bit have_prev = 0;
    logic prev_cyc = 1'b0;

    uart_rx_wb #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .uart_rx    (uart_rx),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_i   (wb_ack_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        if (i < wr_q.size()) return {24'h0, wr_q[i]};
        return 32'hDEAD;
    endfunction

    task automatic clear_obs();
        wr_q.delete();
        we_bad    = 0;
        sig_bad   = 0;
        ferr_cnt  = 0;
        ovr_cnt   = 0;
        last_run  = 0;
        min_gap   = 999;
        have_prev = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drive the first nbits of a frame: start, 8 data bits LSB first, stop.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            uart_rx = f[i];
            wait_cyc(CPB);
        end
    endtask

    // Ack responder, updated just after each rising edge.
    initial begin
        wb_ack_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!wb_cyc_o) cyc_age = 0;
            else cyc_age++;
            case (ack_mode)
                0:       wb_ack_i = wb_cyc_o && (cyc_age >= 2);
                1:       wb_ack_i = 1'b1;
                default: wb_ack_i = 1'b0;
            endcase
        end
    end

    // Bus and pulse observer, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (wb_stb_o !== wb_cyc_o || wb_we_o !== wb_cyc_o) sig_bad++;
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
        if (wb_cyc_o && wb_ack_i) begin
            wr_q.push_back(wb_dat_o);
            if (!wb_we_o) we_bad++;
        end
        if (wb_cyc_o) begin
            if (!prev_cyc) begin
                if (have_prev && gap < min_gap) min_gap = gap;
                run = 0;
            end
            run++;
        end else begin
            if (prev_cyc) begin
                last_run  = run;
                have_prev = 1;
                gap       = 0;
            end
            gap++;
        end
        prev_cyc = wb_cyc_o;
    end

    initial begin
        uart_rx = 1'b1;
        rst_ni  = 1'b0;
        wait_cyc(3);
        chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk("rst_stb", {31'h0, wb_stb_o}, 32'h0);
        chk("rst_we", {31'h0, wb_we_o}, 32'h0);
        chk("rst_dat", {24'h0, wb_dat_o}, 32'h0);
        chk("rst_ferr", {31'h0, frame_err_o}, 32'h0);
        chk("rst_ovr", {31'h0, overrun_o}, 32'h0);
        rst_ni = 1'b1;
        wait_cyc(5);

        // Single frame, ack one cycle after stb
        clear_obs();
        ack_mode = 0;
        send_frame(8'h55, 1'b1, 10);
        wait_cyc(30);
        chk("t1_nwr", wr_q.size(), 1);
        chk("t1_dat", wr_at(0), 32'h55);
        chk("t1_we", we_bad, 0);
        chk("t1_cyc_len", last_run, 2);
        chk("t1_ferr", ferr_cnt, 0);
        chk("t1_ovr", ovr_cnt, 0);

        // Back-to-back frames, ack tied high
        clear_obs();
        ack_mode = 1;
        send_frame(8'hA3, 1'b1, 10);
        send_frame(8'h0F, 1'b1, 10);
        send_frame(8'hFF, 1'b1, 10);
        wait_cyc(30);
        chk("t2_nwr", wr_q.size(), 3);
        chk("t2_dat0", wr_at(0), 32'hA3);
        chk("t2_dat1", wr_at(1), 32'h0F);
        chk("t2_dat2", wr_at(2), 32'hFF);
        chk("t2_gap", {31'h0, min_gap >= 1}, 32'h1);
        chk("t2_sig", sig_bad, 0);

        // Short low glitch on an idle line
        clear_obs();
        uart_rx = 1'b0;
        wait_cyc(5);
        uart_rx = 1'b1;
        wait_cyc(40);
        chk("t3_nwr", wr_q.size(), 0);
        chk("t3_ferr", ferr_cnt, 0);

        // Bad stop bit, line held low, then a good frame
        clear_obs();
        send_frame(8'h41, 1'b0, 10);
        wait_cyc(100);
        uart_rx = 1'b1;
        wait_cyc(20);
        chk("t4_ferr_pre", ferr_cnt, 1);
        chk("t4_nwr_pre", wr_q.size(), 0);
        send_frame(8'h42, 1'b1, 10);
        wait_cyc(30);
        chk("t4_ferr", ferr_cnt, 1);
        chk("t4_nwr", wr_q.size(), 1);
        chk("t4_dat", wr_at(0), 32'h42);

        // Stalled bus: FIFO fills, last two bytes overrun
        clear_obs();
        ack_mode = 2;
        for (int b = 1; b <= 6; b++) send_frame(8'(b), 1'b1, 10);
        wait_cyc(10);
        chk("t5_ovr", ovr_cnt, 2);
        chk("t5_nwr_stall", wr_q.size(), 0);
        chk("t5_cyc_stall", {31'h0, wb_cyc_o}, 32'h1);
        chk("t5_dat_stall", {24'h0, wb_dat_o}, 32'h01);
        ack_mode = 1;
        wait_cyc(40);
        chk("t5_nwr", wr_q.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t5_dat%0d", i), wr_at(i), 32'(i + 1));
        chk("t5_ovr_end", ovr_cnt, 2);

        // Reset mid-frame while a bus cycle is pending
        clear_obs();
        ack_mode = 2;
        send_frame(8'h10, 1'b1, 10);
        wait_cyc(5);
        chk("t6_cyc_pre", {31'h0, wb_cyc_o}, 32'h1);
        send_frame(8'h77, 1'b1, 5);
        rst_ni  = 1'b0;
        uart_rx = 1'b1;
        wait_cyc(1);
        chk("t6_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk("t6_stb", {31'h0, wb_stb_o}, 32'h0);
        chk("t6_we", {31'h0, wb_we_o}, 32'h0);
        chk("t6_dat", {24'h0, wb_dat_o}, 32'h0);
        rst_ni   = 1'b1;
        ack_mode = 1;
        wait_cyc(40);
        chk("t6_empty", wr_q.size(), 0);
        send_frame(8'h33, 1'b1, 10);
        wait_cyc(30);
        chk("t6_nwr", wr_q.size(), 1);
        chk("t6_dat_new", wr_at(0), 32'h33);
        chk("t6_ferr", ferr_cnt, 0);
        chk("t6_sig", sig_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
